// File: rtl/register_file_mp.sv
// Multi-port architectural register file: prioritised write ports, optional
// same-cycle write-to-read forwarding, and a per-register pending-write scoreboard.
module register_file_mp #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned NREGS  = 32,
   parameter  int unsigned NREAD  = 2,
   parameter  int unsigned NWRITE = 2,
   parameter  int unsigned BYPASS = 1,
   localparam int unsigned AW     = $clog2(NREGS)
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic [NWRITE-1:0]              wen,
   input  logic [NWRITE-1:0][AW-1:0]      wsel,
   input  logic [NWRITE-1:0][DATA_W-1:0]  wdat,
   input  logic [NREAD-1:0][AW-1:0]       rsel,
   output logic [NREAD-1:0][DATA_W-1:0]   rdat,
   output logic [NREAD-1:0]               rbusy,
   input  logic                           iss_en,
   input  logic [AW-1:0]                  iss_sel,
   input  logic                           flush
);

   logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NREGS-1:0]             busy_q, busy_d;

   // Next state: ascending port order lets the highest-index write win; the
   // scoreboard applies writeback clear, then issue set, then flush.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int unsigned w = 0; w < NWRITE; w++) begin
         if (wen[w] && (wsel[w] != '0)) begin
            regs_d[wsel[w]] = wdat[w];
            busy_d[wsel[w]] = 1'b0;
         end
      end
      if (iss_en && (iss_sel != '0)) begin
         busy_d[iss_sel] = 1'b1;
      end
      if (flush) begin
         busy_d = '0;
      end
   end

   // Read ports; a forwarded write also hides the busy flag since its data is already here.
   always_comb begin
      rdat  = '0;
      rbusy = '0;
      for (int unsigned i = 0; i < NREAD; i++) begin
         rdat[i]  = regs_q[rsel[i]];
         rbusy[i] = busy_q[rsel[i]];
         if (BYPASS != 0) begin
            for (int unsigned w = 0; w < NWRITE; w++) begin
               if (wen[w] && (wsel[w] == rsel[i])) begin
                  rdat[i]  = wdat[w];
                  rbusy[i] = 1'b0;
               end
            end
         end
         if (rsel[i] == '0) begin
            rdat[i]  = '0;
            rbusy[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         regs_q <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

endmodule
